// File: rtl/ch_inst_sequencer_pkg.sv
// Shared types and instruction encodings for the channel instruction sequencer.
// Instruction vectors are one-hot; bit order matches the six instruction outputs.
package ch_inst_sequencer_pkg;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      ST_PULSE   = 4'd1,
      GAP1       = 4'd2,
      MODE_PULSE = 4'd3,
      GAP2       = 4'd4,
      ARMED      = 4'd5,
      STOP_WAIT  = 4'd6,
      SP_PULSE   = 4'd7,
      GAP3       = 4'd8,
      STOPPED    = 4'd9,
      RO_PULSE   = 4'd10,
      READOUT    = 4'd11
   } ctrl_state_t;

   typedef enum logic [1:0] {
      CMD_NOP     = 2'd0,
      CMD_START   = 2'd1,
      CMD_STOP    = 2'd2,
      CMD_READOUT = 2'd3
   } cmd_t;

   typedef enum logic [1:0] {
      MODE_NONE    = 2'd0,
      MODE_SAMPLE1 = 2'd1,
      MODE_SAMPLE2 = 2'd2,
      MODE_SAMPLE4 = 2'd3
   } mode_t;

   localparam int unsigned NumInst = 6;
   typedef logic [NumInst-1:0] inst_vec_t;

   localparam int unsigned IdxStart   = 0;
   localparam int unsigned IdxStart1  = 1;
   localparam int unsigned IdxStart2  = 2;
   localparam int unsigned IdxStart4  = 3;
   localparam int unsigned IdxStop    = 4;
   localparam int unsigned IdxReadout = 5;

   localparam inst_vec_t InstNone    = 6'b000000;
   localparam inst_vec_t InstStart   = 6'b000001;
   localparam inst_vec_t InstStart1  = 6'b000010;
   localparam inst_vec_t InstStart2  = 6'b000100;
   localparam inst_vec_t InstStart4  = 6'b001000;
   localparam inst_vec_t InstStop    = 6'b010000;
   localparam inst_vec_t InstReadout = 6'b100000;

   function automatic inst_vec_t mode_inst(mode_t mode);
      inst_vec_t v;
      case (mode)
         MODE_SAMPLE1: v = InstStart1;
         MODE_SAMPLE2: v = InstStart2;
         MODE_SAMPLE4: v = InstStart4;
         default:      v = InstNone;
      endcase
      return v;
   endfunction

   function automatic logic mode_valid(mode_t mode);
      return mode != MODE_NONE;
   endfunction

   function automatic logic state_ready(ctrl_state_t s);
      return s inside {IDLE, ARMED, STOP_WAIT, STOPPED};
   endfunction

endpackage

// File: rtl/ch_inst_sequencer_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Resets to zero asynchronously so a stale request never survives reset.
module ch_inst_sequencer_sync_2ff #(
   parameter int unsigned Width = 1
) (
   input  logic             clk,
   input  logic             RSTB,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk or negedge RSTB) begin
      if (!RSTB) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/ch_inst_sequencer.sv
// Host command sequencer producing flop-driven, mutually exclusive instruction pulses
// for the channel state machines, with delayed auto-stop and trigger-count capture.
module ch_inst_sequencer
   import ch_inst_sequencer_pkg::*;
#(
   parameter int unsigned NUM_CH  = 8,
   parameter int unsigned PULSE_W = 4,
   parameter int unsigned GAP_W   = 2,
   parameter int unsigned DLY_W   = 8
) (
   input  logic                clk,
   input  logic                RSTB,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd,
   input  logic [1:0]          cmd_mode,
   input  logic                auto_stop,
   input  logic [DLY_W-1:0]    stop_delay,
   input  logic                STOP_REQUEST,
   input  logic [3*NUM_CH-1:0] trig_cnt_flat,
   input  logic                readout_done,
   output logic                INST_START,
   output logic                start1,
   output logic                start2,
   output logic                start4,
   output logic                INST_STOP,
   output logic                INST_READOUT,
   output logic [2:0]          events_max,
   output logic                events_valid,
   output logic [3:0]          seq_state,
   output logic                cmd_err
);

   localparam int unsigned TimeCntW = $clog2(PULSE_W + GAP_W) + 1;
   localparam int unsigned CntW     = (DLY_W > TimeCntW) ? DLY_W : TimeCntW;

   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t PulseLast = cnt_t'(PULSE_W - 1);
   localparam cnt_t GapLast   = cnt_t'(GAP_W - 1);
   localparam cnt_t CntOne    = cnt_t'(1);

   ctrl_state_t state_q;
   cnt_t        cnt_q;
   mode_t       mode_q;
   inst_vec_t   inst_q;
   logic [2:0]  events_max_q;
   logic        events_valid_q;
   logic        cmd_err_q;
   logic        done_q;

   logic        stop_sync;
   logic        accept;
   cmd_t        cmd_c;
   mode_t       mode_c;
   logic [2:0]  trig_max;

   ch_inst_sequencer_sync_2ff #(
      .Width (1)
   ) u_stop_sync (
      .clk  (clk),
      .RSTB (RSTB),
      .d    (STOP_REQUEST),
      .q    (stop_sync)
   );

   assign cmd_c     = cmd_t'(cmd);
   assign mode_c    = mode_t'(cmd_mode);
   assign cmd_ready = state_ready(state_q);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      trig_max = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (trig_cnt_flat[3*i +: 3] > trig_max) begin
            trig_max = trig_cnt_flat[3*i +: 3];
         end
      end
   end

   // One counter times every pulse and gap; STOP_WAIT reuses it for the stop delay.
   always_ff @(posedge clk or negedge RSTB) begin
      if (!RSTB) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         mode_q         <= MODE_NONE;
         inst_q         <= InstNone;
         events_max_q   <= '0;
         events_valid_q <= 1'b0;
         cmd_err_q      <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         cmd_err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  if (cmd_c == CMD_START && mode_valid(mode_c)) begin
                     state_q <= ST_PULSE;
                     inst_q  <= InstStart;
                     cnt_q   <= PulseLast;
                     mode_q  <= mode_c;
                  end else if (cmd_c != CMD_NOP) begin
                     cmd_err_q <= 1'b1;
                  end
               end
            end
            ST_PULSE: begin
               if (cnt_q == '0) begin
                  state_q <= GAP1;
                  inst_q  <= InstNone;
                  cnt_q   <= GapLast;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            GAP1: begin
               if (cnt_q == '0) begin
                  state_q <= MODE_PULSE;
                  inst_q  <= mode_inst(mode_q);
                  cnt_q   <= PulseLast;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            MODE_PULSE: begin
               if (cnt_q == '0) begin
                  state_q <= GAP2;
                  inst_q  <= InstNone;
                  cnt_q   <= GapLast;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            GAP2: begin
               if (cnt_q == '0) begin
                  state_q <= ARMED;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            ARMED: begin
               // An explicit STOP takes priority over a simultaneous auto-stop.
               if (accept && cmd_c == CMD_STOP) begin
                  state_q <= SP_PULSE;
                  inst_q  <= InstStop;
                  cnt_q   <= PulseLast;
               end else if (accept && cmd_c != CMD_NOP) begin
                  cmd_err_q <= 1'b1;
               end else if (auto_stop && stop_sync) begin
                  if (stop_delay == '0) begin
                     state_q <= SP_PULSE;
                     inst_q  <= InstStop;
                     cnt_q   <= PulseLast;
                  end else begin
                     state_q <= STOP_WAIT;
                     cnt_q   <= cnt_t'(stop_delay);
                  end
               end
            end
            STOP_WAIT: begin
               if ((accept && cmd_c == CMD_STOP) || cnt_q == CntOne) begin
                  state_q <= SP_PULSE;
                  inst_q  <= InstStop;
                  cnt_q   <= PulseLast;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
               if (accept && cmd_c != CMD_NOP && cmd_c != CMD_STOP) begin
                  cmd_err_q <= 1'b1;
               end
            end
            SP_PULSE: begin
               if (cnt_q == '0) begin
                  state_q <= GAP3;
                  inst_q  <= InstNone;
                  cnt_q   <= GapLast;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            GAP3: begin
               if (cnt_q == '0) begin
                  state_q        <= STOPPED;
                  events_max_q   <= trig_max;
                  events_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            STOPPED: begin
               if (accept) begin
                  if (cmd_c == CMD_READOUT) begin
                     state_q <= RO_PULSE;
                     inst_q  <= InstReadout;
                     cnt_q   <= PulseLast;
                  end else if (cmd_c == CMD_START && mode_valid(mode_c)) begin
                     state_q        <= ST_PULSE;
                     inst_q         <= InstStart;
                     cnt_q          <= PulseLast;
                     mode_q         <= mode_c;
                     events_valid_q <= 1'b0;
                  end else if (cmd_c != CMD_NOP) begin
                     cmd_err_q <= 1'b1;
                  end
               end
            end
            RO_PULSE: begin
               if (cnt_q == '0) begin
                  state_q <= READOUT;
                  inst_q  <= InstNone;
                  cnt_q   <= GapLast;
                  done_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CntOne;
               end
            end
            READOUT: begin
               // A done seen early is held so the post-readout gap is still honoured.
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CntOne;
               end
               if ((done_q || readout_done) && cnt_q == '0) begin
                  state_q        <= IDLE;
                  events_valid_q <= 1'b0;
                  done_q         <= 1'b0;
               end else if (readout_done) begin
                  done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               inst_q  <= InstNone;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign INST_START   = inst_q[IdxStart];
   assign start1       = inst_q[IdxStart1];
   assign start2       = inst_q[IdxStart2];
   assign start4       = inst_q[IdxStart4];
   assign INST_STOP    = inst_q[IdxStop];
   assign INST_READOUT = inst_q[IdxReadout];
   assign events_max   = events_max_q;
   assign events_valid = events_valid_q;
   assign seq_state    = state_q;
   assign cmd_err      = cmd_err_q;

endmodule

// File: doc/ch_inst_sequencer.md
Name: ch_inst_sequencer

Overview:
- Clocked command sequencer that drives the per-channel sampling state machines.
- Converts host commands (START with mode, STOP, READOUT) into glitch-free, mutually exclusive instruction pulses: INST_START, start1, start2, start4, INST_STOP and INST_READOUT.
- Consumes the OR'd STOP_REQUEST from all channels to auto-stop after a programmable delay.
- Latches the largest per-channel trigger count for readout sizing.

Parameters:
NUM_CH, 8, number of channels whose trigger_cnt buses are monitored
PULSE_W, 4, clock cycles each instruction pulse is held high (>=2)
GAP_W, 2, minimum all-low clock cycles between consecutive instruction pulses (>=2)
DLY_W, 8, width of stop_delay counter

Ports:
clk  in  1  system clock
RSTB  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command this cycle
cmd  in  2  cmd_t: CMD_NOP=0, CMD_START=1, CMD_STOP=2, CMD_READOUT=3
cmd_mode  in  2  mode_t for CMD_START: MODE_SAMPLE1=1, MODE_SAMPLE2=2, MODE_SAMPLE4=3
auto_stop  in  1  enable auto-stop on STOP_REQUEST
stop_delay  in  DLY_W  cycles between synchronized STOP_REQUEST and INST_STOP
STOP_REQUEST  in  1  asynchronous OR of channel stop requests
trig_cnt_flat  in  3*NUM_CH  channel trigger counts, channel i at [3i+2:3i]
readout_done  in  1  one-cycle pulse from readout logic
INST_START, start1, start2, start4, INST_STOP, INST_READOUT  out  1 each  instruction pulses to channels
events_max  out  3  max trig_cnt over channels, latched at stop
events_valid  out  1  events_max valid (STOPPED/READOUT states)
seq_state  out  4  ctrl_state_t, for debug/status
cmd_err  out  1  one-cycle pulse on an accepted but illegal command

Behaviour:
- Reset (RSTB low, async):
  - State IDLE.
  - All six instruction outputs 0; events_max 0; events_valid 0; cmd_err 0; counters 0.
  - cmd_ready=1 after reset.
- Output timing:
  - Instruction outputs come directly from flops; no combinational glitches are allowed, because the channels are edge-sensitive.
  - At most one instruction output is high in any cycle.
  - Every pulse is exactly PULSE_W cycles long and is followed by at least GAP_W all-low cycles.
- STOP_REQUEST: passes through a 2-FF synchronizer (stop_sync). Only the synchronized level is used.
- Command handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready=1 in IDLE, ARMED, STOP_WAIT and STOPPED; 0 in all pulse, gap and READOUT states.
  - CMD_NOP is accepted with no effect.
  - An illegal command is accepted, ignored, and pulses cmd_err for 1 cycle; the state is unchanged.
- States and transitions:
  - IDLE:
    - START with a valid mode -> ST_PULSE.
    - START with mode 0, STOP, or READOUT -> cmd_err.
  - ST_PULSE: INST_START high PULSE_W -> GAP1 (GAP_W) -> MODE_PULSE.
  - MODE_PULSE: start1/start2/start4 per the latched mode, high PULSE_W -> GAP2 (GAP_W) -> ARMED.
  - ARMED:
    - STOP cmd -> SP_PULSE.
    - auto_stop && stop_sync -> STOP_WAIT with the counter loaded from stop_delay; if stop_delay==0, go directly to SP_PULSE.
    - START or READOUT -> cmd_err.
  - STOP_WAIT:
    - Counter decrements each cycle; at 1 -> SP_PULSE, giving exactly stop_delay cycles from the ARMED exit.
    - STOP cmd -> SP_PULSE immediately.
    - auto_stop deassertion does not cancel the wait.
  - SP_PULSE: INST_STOP high PULSE_W -> GAP3.
  - GAP3: on its last cycle, events_max <= max over channels of trig_cnt (unsigned compare) -> STOPPED with events_valid=1.
  - STOPPED:
    - READOUT -> RO_PULSE.
    - START with a valid mode -> ST_PULSE, re-arming without readout; events_valid drops to 0.
    - STOP -> cmd_err.
  - RO_PULSE: INST_READOUT high PULSE_W -> READOUT.
  - READOUT:
    - Waits for readout_done, then -> IDLE; events_valid stays 1 until leaving READOUT.
    - readout_done in any other state is ignored.
- Boundary conditions:
  - stop_sync high while in a pulse or gap state is ignored; it is re-evaluated in ARMED. A stale STOP_REQUEST from a previous run is cleared by INST_START before ARMED is reached, because of the GAP_W>=2 and 2-FF latency.
  - A command and auto-stop in the same ARMED cycle: the explicit STOP command wins (SP_PULSE); both paths end in SP_PULSE anyway.
  - RSTB asserted mid-pulse drops the pulse immediately, asynchronously.

Decomposition:
- types_pkg additions:
  - ctrl_state_t: IDLE, ST_PULSE, GAP1, MODE_PULSE, GAP2, ARMED, STOP_WAIT, SP_PULSE, GAP3, STOPPED, RO_PULSE, READOUT.
  - cmd_t and mode_t with the encodings above.
- sync_2ff: a generic 2-flop synchronizer with async active-low reset, used for STOP_REQUEST.
- Pulse and gap timing share a single down-counter inside ch_inst_sequencer.

Test Plan:
- Reset, then START mode=MODE_SAMPLE2 -> INST_START high cycles 1-4 after accept, 2 low, start2 high 4 cycles, 2 low, seq_state=ARMED; start1/start4 never high.
- ARMED, auto_stop=1, stop_delay=5, assert STOP_REQUEST -> INST_STOP rises 2+5 cycles later for 4 cycles; with trig_cnt={1,3,2,...} -> events_max=3, events_valid=1.
- STOPPED, READOUT -> INST_READOUT high 4 cycles, cmd_ready=0 until readout_done, then IDLE and events_valid=0.
- Illegal commands: READOUT in IDLE, START in ARMED, START with mode 0 -> cmd_err one-cycle pulse each, state unchanged, no instruction output.
- STOP_WAIT with stop_delay=200, STOP cmd at cycle 10 -> INST_STOP next cycle; separately, stop_delay=0 -> INST_STOP the cycle after ARMED exit.
- RSTB pulsed low mid start4 pulse -> all outputs 0 asynchronously, IDLE, cmd_ready=1; a continuous monitor asserts one-hot-or-zero instruction outputs throughout all tests.
